core_boot_ctrl: RTL

Boot and run sequencer for the single-cycle RISC-V CORE. It holds the core in reset and accepts a stream of instruction words over a valid/ready handshake. Each accepted word is written into instruction memory through a dedicated write port. When the load completes, or on an explicit run request, it releases the core's reset, counts run cycles, and returns the core to reset on a halt request.

---
 rtl/core_boot_ctrl_if.sv | 14 +
 rtl/core_boot_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/core_boot_ctrl_if.sv
// Instruction loader stream: the loader drives words with valid, the
// boot controller answers with ready.
interface core_boot_ctrl_if #(
    parameter int DATA_W = 32
);
    // A word transfers on a rising clock edge where LOAD_VALID and LOAD_READY are both high;
    // LOAD_DATA must be stable whenever LOAD_VALID is high, and LOAD_READY never depends on LOAD_VALID.
    logic [DATA_W-1:0] LOAD_DATA;
    logic              LOAD_VALID;
    logic              LOAD_READY;

    modport master (output LOAD_DATA, output LOAD_VALID, input LOAD_READY);
    modport slave  (input LOAD_DATA, input LOAD_VALID, output LOAD_READY);
endinterface

// File: rtl/core_boot_ctrl.sv
// Boot/run sequencer: loads instruction memory from a word stream while the
// core is held in reset, then releases the core and counts its run cycles.
module core_boot_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START_LOAD,
    input  logic              START_RUN,
    input  logic              HALT_REQ,
    input  logic [ADDR_W:0]   LOAD_LEN,
    core_boot_ctrl_if.slave   ld,
    output logic              IMEM_WE,
    output logic [ADDR_W-1:0] IMEM_WADDR,
    output logic [DATA_W-1:0] IMEM_WDATA,
    output logic              CORE_RESET_N,
    output logic              BUSY,
    output logic              RUNNING,
    output logic [31:0]       CYCLE_COUNT,
    output logic              ERR,
    output logic [1:0]        STATE_DBG
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic                busy_q, busy_d;
    logic                running_q, running_d;
    logic [31:0]         cyc_q, cyc_d;
    logic                err_q, err_d;
    logic                hs;
    logic                len_ok;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            running_q    <= 1'b0;
            cyc_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            running_q    <= running_d;
            cyc_q        <= cyc_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cyc_d   = cyc_q;
        err_d   = err_q;
        hs      = ld.LOAD_VALID && (state_q == S_LOAD);
        len_ok  = (LOAD_LEN != '0) && (LOAD_LEN <= MAX_LEN);

        // A word accepted this cycle is always written, even when a halt aborts the load.
        if (hs) begin
            we_d    = 1'b1;
            waddr_d = cnt_q[ADDR_W-1:0];
            wdata_d = ld.LOAD_DATA;
            cnt_d   = cnt_q + ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (START_LOAD) begin
                    if (len_ok) begin
                        len_d   = LOAD_LEN;
                        cnt_d   = '0;
                        cyc_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (START_RUN) begin
                    cyc_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            S_LOAD: begin
                if (HALT_REQ)                          state_d = S_IDLE;
                else if (hs && (cnt_q == len_q - ONE)) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                state_d = HALT_REQ ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (HALT_REQ)            state_d = S_IDLE;
                else if (cyc_q != '1)    cyc_d = cyc_q + 32'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered from the next state so they line up with state_q.
        busy_d       = (state_d == S_LOAD);
        core_rst_n_d = (state_d == S_RUN);
        running_d    = (state_d == S_RUN);
    end

    assign ld.LOAD_READY = (state_q == S_LOAD);
    assign IMEM_WE       = we_q;
    assign IMEM_WADDR    = waddr_q;
    assign IMEM_WDATA    = wdata_q;
    assign CORE_RESET_N  = core_rst_n_q;
    assign BUSY          = busy_q;
    assign RUNNING       = running_q;
    assign CYCLE_COUNT   = cyc_q;
    assign ERR           = err_q;
    assign STATE_DBG     = state_q;

endmodule
